// File: rtl/input_conditioner.sv
// input_conditioner: multi-channel front end for asynchronous board inputs.
// Each channel goes through a flop synchronizer and an optional polarity inversion.
// It is then debounced by a per-channel stability counter and edge-detected,
// so game logic only ever sees clean levels and one-cycle pulses.
//
// Optional feature macro: INPUT_CONDITIONER_DEBOUNCE_EN
//   defined   : per-channel debounce counters; level follows a sample held for
//               DEBOUNCE_CYCLES consecutive cycles (latency STAGES + DEBOUNCE_CYCLES)
//   undefined : no counters; level follows the synchronized sample every cycle
//               (latency STAGES + 1), DEBOUNCE_CYCLES has no effect
//
// Parameters:
//   CHANNELS        number of independent channels (>=1)
//   STAGES          synchronizer flops per channel (>=2)
//   DEBOUNCE_CYCLES stability cycles required before level changes (>=1)
//   RESET_VALUE     raw (pre-inversion) reset value of each synchronizer chain
//   INVERT          per-channel active-low mask
//
// Ports:
//   clk    in   1         system clock
//   rst    in   1         synchronous active-high reset
//   in     in   CHANNELS  asynchronous raw inputs
//   level  out  CHANNELS  debounced, polarity-corrected level
//   rise   out  CHANNELS  one-cycle pulse on level 0->1
//   fall   out  CHANNELS  one-cycle pulse on level 1->0
module input_conditioner #(
  parameter int unsigned          CHANNELS        = 8,
  parameter int unsigned          STAGES          = 2,
  parameter int unsigned          DEBOUNCE_CYCLES = 16,
  parameter logic [CHANNELS-1:0]  RESET_VALUE     = '0,
  parameter logic [CHANNELS-1:0]  INVERT          = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  // Reject illegal configurations at elaboration.
  if (CHANNELS < 1 || STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("input_conditioner: illegal parameter combination");
  end

  logic [CHANNELS-1:0] r_sync [STAGES];
  logic [CHANNELS-1:0] w_s;
  logic [CHANNELS-1:0] w_level_nxt;
  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;

  // Synchronizer chain; stage 0 is the only flop that sees the raw input.
  always_ff @(posedge clk) begin : p_sync
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_sync[k] <= RESET_VALUE;
      end
    end else begin
      r_sync[0] <= in;
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[STAGES-1] ^ INVERT;

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt     [CHANNELS];
  logic [CNT_W-1:0] w_cnt_nxt [CHANNELS];

  // Stability counter: any sample matching the current level discards progress,
  // and the terminal count commits the new level instead of wrapping.
  always_comb begin : p_debounce
    w_level_nxt = r_level;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_s[i] != r_level[i]) begin
        if (r_cnt[i] == CNT_TERM) begin
          w_level_nxt[i] = w_s[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin : p_cnt
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        r_cnt[i] <= '0;
      end else begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end
`else
  // Without debounce the level simply tracks the synchronized sample.
  always_comb begin : p_debounce
    w_level_nxt = w_s;
  end
`endif

  // Level plus registered edge pulses; a pulse coincides with the cycle in
  // which level first shows the new value.
  always_ff @(posedge clk) begin : p_level
    if (rst) begin
      r_level <= RESET_VALUE ^ INVERT;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_rise  <= w_level_nxt & ~r_level;
      r_fall  <= ~w_level_nxt & r_level;
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Multi-channel input front end for asynchronous board inputs (buttons, switches, coin/start lines). Each channel is brought into the `clk` domain through a parametrised flip-flop synchronizer chain, optionally polarity-inverted, debounced by a per-channel stability counter, and edge-detected. Game logic consumes the clean `level` plus one-cycle `rise`/`fall` pulses directly; no raw input reaches game logic.

## Interface
- `CHANNELS`, 8: number of independent input channels (≥1).
- `STAGES`, 2: synchronizer flip-flops per channel (≥2).
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a changed sample must persist before `level` follows (≥1). Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- `RESET_VALUE`, `{CHANNELS{1'b0}}`: per-channel reset value of the synchronizer chain (raw, pre-inversion).
- `INVERT`, `{CHANNELS{1'b0}}`: per-channel polarity mask; bit=1 means the input is active-low.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  CHANNELS  asynchronous raw inputs.
- `level`  out  CHANNELS  debounced, polarity-corrected level.
- `rise`  out  CHANNELS  one-cycle pulse when `level[i]` goes 0→1.
- `fall`  out  CHANNELS  one-cycle pulse when `level[i]` goes 1→0.

## Operation
Per channel `i`, fully independent:
- Sync chain: `in[i]` shifts through `STAGES` flops; `s[i]` = last stage XOR `INVERT[i]`.
- Debounce (counter `cnt[i]`, register `level[i]`):
  - `s[i] == level[i]`: `cnt[i] <= 0`.
  - `s[i] != level[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `level[i] <= s[i]`, `cnt[i] <= 0`.
  - otherwise: `cnt[i] <= cnt[i]+1`.
  - Any return of `s[i]` to `level[i]` before terminal count discards progress (bounce rejection). Counter never wraps.
- Edge detect: register `level_q[i] <= level[i]`; `rise[i] = level[i] & ~level_q[i]`, `fall[i] = ~level[i] & level_q[i]` (decoded from flops only, no path from `in`).
- Reset (`rst`=1 at a clock edge): sync flops ← `RESET_VALUE[i]`; `level[i]` and `level_q[i]` ← `RESET_VALUE[i] ^ INVERT[i]`; `cnt[i]` ← 0. Hence `rise`=`fall`=0 during reset and in the first cycle after; `level` = `RESET_VALUE ^ INVERT`.
- Reset mid-count or mid-bounce aborts all state; no pulse is generated for the aborted transition.
- Simultaneous transitions on several channels are handled independently in the same cycle.

## Timing
- `s[i]` follows a stable `in[i]` change `STAGES` edges later.
- `level[i]` changes `STAGES + DEBOUNCE_CYCLES` edges after a clean, held `in[i]` change.
- `rise`/`fall` are high for exactly the one cycle in which `level` shows the new value; they are never both high on one channel.
- Pulses shorter than `DEBOUNCE_CYCLES` cycles at `s[i]` never reach `level`.

## Configuration
- `INPUT_CONDITIONER_DEBOUNCE_EN` defined: debounce counters present, behaviour as above.
- Not defined: counters are not synthesised; `level[i] <= s[i]` every cycle (equivalent to `DEBOUNCE_CYCLES`=1), latency `STAGES + 1`; `DEBOUNCE_CYCLES` ignored. Sync, inversion, edge detect and reset unchanged.

## Test plan
Bench config `CHANNELS`=4, `STAGES`=2, `DEBOUNCE_CYCLES`=4, `RESET_VALUE`=0, `INVERT`=4'b1000, macro defined unless stated.
- Reset: `rst`=1 for 2 cycles with `in`=4'b1111 → `level`=4'b1000, `rise`=`fall`=0 during reset and the cycle after.
- Clean press: after reset `in`=4'b0001 held → `level[0]`=1 exactly 6 edges later, `rise[0]` high one cycle, other channels unchanged, no `fall`.
- Bounce: `in[1]` high 3 cycles, low 1, then high held → no pulse during bounce; `level[1]`/`rise[1]` 6 edges after final rising edge of `in[1]`.
- Inverted channel: `in[3]`=0 from reset (`level[3]`=1, no `rise`); drive `in[3]`=1 → `fall[3]` pulse and `level[3]`=0 6 edges later.
- Reset mid-count: `in[2]` rises, `rst` asserted 1 cycle at edge 5 while `in[2]` stays 1 → no `rise[2]` before reset; `level[2]` rises 6 edges after `rst` deasserts.
- Macro undefined: `in[0]` 1-cycle glitch → `level[0]` pulses 1 cycle 3 edges later with `rise[0]` then `fall[0]` on consecutive cycles.
